// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, SR/Cause field layout.
// The Count/Compare registers only exist when CP0_COUNT_EN is defined.
package cp0_pkg;

  localparam logic [4:0] RegCount   = 5'd9;
  localparam logic [4:0] RegCompare = 5'd11;
  localparam logic [4:0] RegSr      = 5'd12;
  localparam logic [4:0] RegCause   = 5'd13;
  localparam logic [4:0] RegEpc     = 5'd14;
  localparam logic [4:0] RegPrid    = 5'd15;

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcAdel = 5'd4;
  localparam logic [4:0] ExcAdes = 5'd5;
  localparam logic [4:0] ExcRi   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;

  localparam int unsigned SrIe       = 0;
  localparam int unsigned SrExl      = 1;
  localparam int unsigned SrImLo     = 10;
  localparam int unsigned CauseExcLo = 2;
  localparam int unsigned CauseIpLo  = 10;
  localparam int unsigned CauseBd    = 31;

  localparam logic [31:0] DefaultHandlerPc = 32'h0000_4180;
  localparam logic [31:0] DefaultPrid      = 32'h4A43_0001;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exccode;
  } cause_t;

  function automatic logic [31:0] sr_word(sr_t s);
    logic [31:0] w;
    w = '0;
    w[SrImLo +: 6] = s.im;
    w[SrExl]       = s.exl;
    w[SrIe]        = s.ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_word(cause_t c);
    logic [31:0] w;
    w = '0;
    w[CauseBd]           = c.bd;
    w[CauseIpLo +: 6]    = c.ip;
    w[CauseExcLo +: 5]   = c.exccode;
    return w;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0; only instantiated when CP0_COUNT_EN is defined.
// timer_pend latches on Count == Compare and clears on a Compare write.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pend
);

  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        pend_q, pend_d;

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    pend_d    = pend_q | (count_q == compare_q);
    if (wr_en && addr == RegCount) begin
      count_d = wdata;
    end
    if (wr_en && addr == RegCompare) begin
      compare_d = wdata;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      compare_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign count      = count_q;
  assign compare    = compare_q;
  assign timer_pend = pend_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller beside the M stage: SR/Cause/EPC, flush and redirect.
// Define CP0_COUNT_EN to add Count/Compare and the timer interrupt on hwint[5].
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = DefaultHandlerPc,
  parameter logic [31:0] PRID       = DefaultPrid
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_m,
  input  logic        valid_m,
  input  logic [4:0]  exccode_m,
  input  logic        bd_m,
  input  logic [5:0]  hwint,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret_m,
  output logic [31:0] cp0_rdata,
  output logic        exc_req,
  output logic [31:0] exc_pc,
  output logic [31:0] epc_out
);

  sr_t         sr_q, sr_d;
  cause_t      cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pc_hold_q;
  logic        bd_hold_q;
  logic [5:0]  ip_src;
  logic        int_pend, exc_pend;
  logic [31:0] victim_pc, victim_epc;
  logic        victim_bd;

`ifdef CP0_COUNT_EN
  logic [31:0] count, compare;
  logic        timer_pend;

  cp0_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (cp0_we & ~exc_req),
    .addr       (cp0_addr),
    .wdata      (cp0_wdata),
    .count      (count),
    .compare    (compare),
    .timer_pend (timer_pend)
  );

  assign ip_src = {hwint[5] | timer_pend, hwint[4:0]};
`else
  assign ip_src = hwint;
`endif

  // Registered IP gives one cycle of interrupt latency.
  assign int_pend = (|(cause_q.ip & sr_q.im)) & sr_q.ie & ~sr_q.exl;
  assign exc_pend = (exccode_m != ExcInt) & valid_m & ~sr_q.exl;
  assign exc_req  = int_pend | exc_pend;

  // A bubble in M blames the last real instruction that passed through.
  assign victim_pc  = valid_m ? pc_m : pc_hold_q;
  assign victim_bd  = valid_m ? bd_m : bd_hold_q;
  assign victim_epc = (victim_pc - {29'd0, victim_bd, 2'b00}) & ~32'd3;

  always_comb begin
    sr_d       = sr_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    cause_d.ip = ip_src;
    if (exc_req) begin
      sr_d.exl        = 1'b1;
      cause_d.exccode = int_pend ? ExcInt : exccode_m;
      cause_d.bd      = victim_bd;
      epc_d           = victim_epc;
    end else begin
      if (cp0_we) begin
        case (cp0_addr)
          RegSr: begin
            sr_d.im  = cp0_wdata[SrImLo +: 6];
            sr_d.exl = cp0_wdata[SrExl];
            sr_d.ie  = cp0_wdata[SrIe];
          end
          RegEpc:  epc_d = cp0_wdata & ~32'd3;
          default: ;
        endcase
      end
      if (eret_m) begin
        sr_d.exl = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q      <= '0;
      cause_q   <= '0;
      epc_q     <= '0;
      pc_hold_q <= '0;
      bd_hold_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      if (valid_m) begin
        pc_hold_q <= pc_m;
        bd_hold_q <= bd_m;
      end
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      RegSr:      cp0_rdata = sr_word(sr_q);
      RegCause:   cp0_rdata = cause_word(cause_q);
      RegEpc:     cp0_rdata = epc_q;
      RegPrid:    cp0_rdata = PRID;
`ifdef CP0_COUNT_EN
      RegCount:   cp0_rdata = count;
      RegCompare: cp0_rdata = compare;
`endif
      default:    cp0_rdata = '0;
    endcase
  end

  assign exc_pc  = HANDLER_PC;
  assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl in the default build (CP0_COUNT_EN undefined).
// Expected register values are queued when stimulus is applied and compared on readback.
`timescale 1ns/1ps
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_m;
  logic        valid_m;
  logic [4:0]  exccode_m;
  logic        bd_m;
  logic [5:0]  hwint;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret_m;
  logic [31:0] cp0_rdata;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic [31:0] epc_out;

  typedef struct {
    string       name;
    logic [4:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  cp0_exc_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pc_m      (pc_m),
    .valid_m   (valid_m),
    .exccode_m (exccode_m),
    .bd_m      (bd_m),
    .hwint     (hwint),
    .cp0_we    (cp0_we),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .eret_m    (eret_m),
    .cp0_rdata (cp0_rdata),
    .exc_req   (exc_req),
    .exc_pc    (exc_pc),
    .epc_out   (epc_out)
  );

  always #10 clk = ~clk;

  task automatic idle();
    valid_m   = 1'b0;
    exccode_m = 5'd0;
    bd_m      = 1'b0;
    pc_m      = 32'd0;
    cp0_we    = 1'b0;
    cp0_addr  = 5'd0;
    cp0_wdata = 32'd0;
    eret_m    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input logic [4:0] addr, input logic [31:0] val);
    exp_t x;
    x.name = name;
    x.addr = addr;
    x.val  = val;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    hwint   = 6'd0;
    idle();
    #3;
    n_checks++;
    if (exc_req !== 1'b0) $display("FAIL rst_exc_req: got %b want 0", exc_req); else n_pass++;
    n_checks++;
    if (cp0_rdata !== 32'd0) $display("FAIL rst_rdata0: got %h want 0", cp0_rdata); else n_pass++;
    n_checks++;
    if (exc_pc !== 32'h0000_4180) $display("FAIL exc_pc: got %h want 00004180", exc_pc);
    else n_pass++;
    push("rst_sr", 5'd12, 32'd0);
    push("rst_cause", 5'd13, 32'd0);
    push("rst_epc", 5'd14, 32'd0);
    push("rst_prid", 5'd15, 32'h4A43_0001);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cp0_addr = e.addr;
      #1;
      n_checks++;
      if (cp0_rdata !== e.val) $display("FAIL %s: got %h want %h", e.name, cp0_rdata, e.val);
      else n_pass++;
    end
    cp0_addr = 5'd0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_sync_exc();
    valid_m = 1'b1; exccode_m = 5'd4; pc_m = 32'h3010;
    #2;
    n_checks++;
    if (exc_req !== 1'b1) $display("FAIL adel_req: got %b want 1", exc_req); else n_pass++;
    push("adel_sr", 5'd12, 32'h0000_0002);
    push("adel_cause", 5'd13, 32'h0000_0010);
    push("adel_epc", 5'd14, 32'h0000_3010);
    tick(); idle();
    n_checks++;
    if (epc_out !== 32'h3010) $display("FAIL adel_epc_out: got %h want 00003010", epc_out);
    else n_pass++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cp0_addr = e.addr;
      #1;
      n_checks++;
      if (cp0_rdata !== e.val) $display("FAIL %s: got %h want %h", e.name, cp0_rdata, e.val);
      else n_pass++;
    end
    eret_m = 1'b1;
    #1;
    n_checks++;
    if (exc_req !== 1'b0) $display("FAIL eret_req: got %b want 0", exc_req); else n_pass++;
    push("eret_sr", 5'd12, 32'd0);
    tick(); idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cp0_addr = e.addr;
      #1;
      n_checks++;
      if (cp0_rdata !== e.val) $display("FAIL %s: got %h want %h", e.name, cp0_rdata, e.val);
      else n_pass++;
    end
    cp0_addr = 5'd0;
  endtask

  task automatic test_delay_slot();
    valid_m = 1'b1; exccode_m = 5'd5; pc_m = 32'h3024; bd_m = 1'b1;
    #2;
    n_checks++;
    if (exc_req !== 1'b1) $display("FAIL ades_req: got %b want 1", exc_req); else n_pass++;
    push("bd_sr", 5'd12, 32'h0000_0002);
    push("bd_cause", 5'd13, 32'h8000_0014);
    push("bd_epc", 5'd14, 32'h0000_3020);
    tick(); idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cp0_addr = e.addr;
      #1;
      n_checks++;
      if (cp0_rdata !== e.val) $display("FAIL %s: got %h want %h", e.name, cp0_rdata, e.val);
      else n_pass++;
    end
    eret_m = 1'b1;
    tick(); idle();
  endtask

  task automatic test_bubble_int();
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    tick(); idle();
    valid_m = 1'b1; pc_m = 32'h3040;
    tick(); idle();
    hwint = 6'h01;
    #2;
    n_checks++;
    if (exc_req !== 1'b0) $display("FAIL int_latency: got %b want 0", exc_req); else n_pass++;
    tick();
    n_checks++;
    if (exc_req !== 1'b1) $display("FAIL int_req: got %b want 1", exc_req); else n_pass++;
    push("int_sr", 5'd12, 32'h0000_0403);
    push("int_cause", 5'd13, 32'h0000_0400);
    push("int_epc", 5'd14, 32'h0000_3040);
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cp0_addr = e.addr;
      #1;
      n_checks++;
      if (cp0_rdata !== e.val) $display("FAIL %s: got %h want %h", e.name, cp0_rdata, e.val);
      else n_pass++;
    end
    cp0_addr = 5'd0;
  endtask

  task automatic test_nested();
    valid_m = 1'b1; exccode_m = 5'd12; pc_m = 32'h3050;
    #2;
    n_checks++;
    if (exc_req !== 1'b0) $display("FAIL nested_block: got %b want 0", exc_req); else n_pass++;
    push("nest_epc", 5'd14, 32'h0000_3040);
    push("nest_cause", 5'd13, 32'h0000_0400);
    tick(); idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cp0_addr = e.addr;
      #1;
      n_checks++;
      if (cp0_rdata !== e.val) $display("FAIL %s: got %h want %h", e.name, cp0_rdata, e.val);
      else n_pass++;
    end
    cp0_addr = 5'd0;
    eret_m = 1'b1;
    #1;
    n_checks++;
    if (exc_req !== 1'b0) $display("FAIL eret_exl_req: got %b want 0", exc_req); else n_pass++;
    tick(); idle();
    // Pending interrupt and a reserved-instruction in the same cycle: interrupt wins.
    valid_m = 1'b1; exccode_m = 5'd10; pc_m = 32'h3060;
    #2;
    n_checks++;
    if (exc_req !== 1'b1) $display("FAIL int_after_eret: got %b want 1", exc_req); else n_pass++;
    push("prio_epc", 5'd14, 32'h0000_3060);
    push("prio_cause", 5'd13, 32'h0000_0400);
    push("prio_sr", 5'd12, 32'h0000_0403);
    tick(); idle();
    n_checks++;
    if (epc_out !== 32'h3060) $display("FAIL prio_epc_out: got %h want 00003060", epc_out);
    else n_pass++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cp0_addr = e.addr;
      #1;
      n_checks++;
      if (cp0_rdata !== e.val) $display("FAIL %s: got %h want %h", e.name, cp0_rdata, e.val);
      else n_pass++;
    end
    cp0_addr = 5'd0;
  endtask

  task automatic test_mtc0();
    hwint = 6'h20; eret_m = 1'b1;
    tick(); idle();
    #1;
    n_checks++;
    if (exc_req !== 1'b0) $display("FAIL masked_ip: got %b want 0", exc_req); else n_pass++;
    cp0_we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
    tick(); idle();
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FFFF;
    tick(); idle();
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1237;
    #1;
    n_checks++;
    if (cp0_rdata !== 32'h3060) $display("FAIL no_bypass: got %h want 00003060", cp0_rdata);
    else n_pass++;
    tick(); idle();
    cp0_we = 1'b1; cp0_addr = 5'd9; cp0_wdata = 32'd5;
    tick(); idle();
    cp0_we = 1'b1; cp0_addr = 5'd11; cp0_wdata = 32'd7;
    tick(); idle();
    push("wr_sr_mask", 5'd12, 32'h0000_FC03);
    push("wr_cause_ro", 5'd13, 32'h0000_8000);
    push("wr_epc_align", 5'd14, 32'h0000_1234);
    push("count_absent", 5'd9, 32'd0);
    push("compare_absent", 5'd11, 32'd0);
    push("unimpl_reg", 5'd3, 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cp0_addr = e.addr;
      #1;
      n_checks++;
      if (cp0_rdata !== e.val) $display("FAIL %s: got %h want %h", e.name, cp0_rdata, e.val);
      else n_pass++;
    end
    cp0_addr = 5'd0;
  endtask

  task automatic test_suppress();
    eret_m = 1'b1;
    tick(); idle();
    // Interrupt taken during a bubble; the concurrent mtc0 and eret must be dropped.
    cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hAAAA_0000; eret_m = 1'b1;
    #1;
    n_checks++;
    if (exc_req !== 1'b1) $display("FAIL suppress_req: got %b want 1", exc_req); else n_pass++;
    push("sup_epc", 5'd14, 32'h0000_3060);
    push("sup_sr", 5'd12, 32'h0000_FC03);
    push("sup_cause", 5'd13, 32'h0000_8000);
    tick(); idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cp0_addr = e.addr;
      #1;
      n_checks++;
      if (cp0_rdata !== e.val) $display("FAIL %s: got %h want %h", e.name, cp0_rdata, e.val);
      else n_pass++;
    end
    cp0_addr = 5'd0;
  endtask

  initial begin
    test_reset();
    test_sync_exc();
    test_delay_slot();
    test_bubble_int();
    test_nested();
    test_mtc0();
    test_suppress();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS core. It sits beside the M stage and consumes the M-stage exception code and branch-delay flag produced by the exception-detect chain (AdEL/AdES, RI, Ov).
- It combines these with external hardware interrupts from the timers and bridge. It decides when to take an exception, records SR/Cause/EPC, and drives pipeline flush and redirect to the handler.
- It also services mfc0/mtc0/eret from the M stage.

Parameters:
- HANDLER_PC, 32'h0000_4180, redirect target on exception/interrupt.
- PRID, 32'h4A43_0001, read-only value of PRId (reg 15).

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- pc_m  in  32  PC of M-stage instruction.
- valid_m  in  1  M stage holds a real instruction (0 = bubble).
- exccode_m  in  5  M-stage exception code, 0 = none.
- bd_m  in  1  M-stage instruction is in a delay slot.
- hwint  in  6  level hardware interrupts, maps to Cause.IP[15:10].
- cp0_we  in  1  mtc0 in M stage.
- cp0_addr  in  5  CP0 register number (rd field).
- cp0_wdata  in  32  mtc0 data.
- eret_m  in  1  eret in M stage.
- cp0_rdata  out  32  mfc0 read data, combinational.
- exc_req  out  1  take exception this cycle: flush F/D/E/M, redirect.
- exc_pc  out  32  redirect target, HANDLER_PC.
- epc_out  out  32  current EPC, eret target.

Behaviour:
- Registers:
  - SR: IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause: BD[31], IP[15:10], ExcCode[6:2].
  - EPC[31:0], word-aligned.
  - PRId is constant.
- Reset (async, reset_n=0):
  - SR=0, Cause=0, EPC=0, pc_hold=0, bd_hold=0.
  - exc_req=0, cp0_rdata=0.
- Cause.IP <= hwint every clk edge, regardless of EXL. IP is never software-writable.
- int_pend = |(Cause.IP & SR.IM) & SR.IE & !SR.EXL. Uses the registered IP, so there is one cycle of interrupt latency.
- exc_pend = (exccode_m != 0) & valid_m & !SR.EXL.
- exc_req = int_pend | exc_pend, combinational. Interrupt wins over a synchronous exception in the same cycle.
- Hold tracker: on each edge with valid_m=1, pc_hold <= pc_m and bd_hold <= bd_m.
- Victim PC/BD:
  - valid_m=1: pc_m / bd_m.
  - valid_m=0 (bubble): pc_hold / bd_hold.
- On edge with exc_req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_pend ? 0 : exccode_m.
  - Cause.BD <= victim BD.
  - EPC <= (victim BD ? victim PC - 4 : victim PC) with bits [1:0] = 00.
  - Any concurrent mtc0/eret is suppressed; the instruction is flushed.
- eret_m=1 and exc_req=0: SR.EXL <= 0 on the edge. epc_out is valid the same cycle.
- mtc0 (cp0_we=1, exc_req=0):
  - addr 12 writes SR: IM, EXL, IE only.
  - addr 14 writes EPC with [1:0] forced to 00.
  - addr 13 and 15 ignored.
  - Other addresses are ignored unless CP0_COUNT_EN is defined.
- mfc0 reads: 12/13/14/15 return SR/Cause/EPC/PRID; unimplemented addresses return 0.
- A write and a read of the same register in one cycle returns the old value (no bypass).
- Nested exceptions: while EXL=1, all interrupts and exceptions are ignored. EPC/Cause hold.
- exc_pc = HANDLER_PC constantly.

Optional Feature:
- Macro CP0_COUNT_EN.
- Defined:
  - Adds Count (reg 9) and Compare (reg 11), reset 0.
  - Count increments by 1 every clk and wraps at 2^32.
  - mtc0 to 9 loads Count; that cycle's increment is lost.
  - timer_pend sets when Count == Compare and clears on mtc0 to 11.
  - timer_pend is ORed into hwint[5] before IP sampling.
- Undefined: regs 9/11 read 0 and writes are ignored; no timer source exists.

Decomposition:
- Shared package cp0_pkg:
  - Register numbers (SR=12, CAUSE=13, EPC=14, PRID=15, COUNT=9, COMPARE=11).
  - ExcCodes: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - SR/Cause bit positions.
  - Default HANDLER_PC.
- One sub-module: cp0_timer (Count/Compare/timer_pend), instantiated only under CP0_COUNT_EN.

Test Plan:
- Reset, then read 12/13/14 -> 0. Read 15 -> 32'h4A43_0001.
- exccode_m=4, pc_m=32'h3010, bd_m=0, valid_m=1 -> exc_req=1 that cycle. Next cycle: EPC=32'h3010, Cause.ExcCode=4, EXL=1.
- Delay slot: exccode_m=5, pc_m=32'h3024, bd_m=1 -> EPC=32'h3020, Cause[31]=1, ExcCode=5.
- SR=32'h0000_0401 (IM[10], IE), hwint[0] rises during a bubble with pc_hold=32'h3040 -> exc_req one cycle later. EPC=32'h3040, ExcCode=0.
- EXL=1 with hwint active and exccode_m=12 -> exc_req=0, EPC unchanged. Then eret_m=1 -> EXL=0 and the interrupt is taken on the following cycle.
- With CP0_COUNT_EN defined: mtc0 Compare=20, SR=32'h0000_8001 -> timer interrupt taken. mtc0 Compare then clears IP[15].
